// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the multiply/divide resource.
// The ALU control codes here are the same ones the ALU decoder emits.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [3:0] ALUCTL_MULT = 4'b1010;
  localparam logic [3:0] ALUCTL_DIV  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } muldiv_state_t;

  // True for the two codes that route a request into the multiply/divide unit
  function automatic logic isMuldivCode(input logic [3:0] code);
    return (code == ALUCTL_MULT) || (code == ALUCTL_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one iteration of the multiply/divide engine, purely combinational.
// Multiply: acc = {product-high, multiplier}; add-then-shift-right.
// Divide:   acc = {remainder, quotient}; shift-left-then-trial-subtract.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 isDiv_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     operand_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   remShift;
  logic [WIDTH-1:0] diff;

  // Single step; the WIDTH+1-bit sum keeps the carry that shifts into the accumulator
  always_comb begin
    sum      = '0;
    remShift = '0;
    diff     = '0;
    acc_o    = acc_i;
    if (isDiv_i) begin
      // Remainder with the next dividend bit shifted in; it can reach WIDTH+1 bits
      remShift = acc_i[2*WIDTH-1:WIDTH-1];
      // A successful trial always leaves a difference below the divisor, so WIDTH bits suffice
      diff     = remShift[WIDTH-1:0] - operand_i;
      if (remShift >= {1'b0, operand_i}) begin
        acc_o = {diff, acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {remShift[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencing controller for the MIPS mult/div resource.
// Accepts a request in IDLE, runs WIDTH iterations of muldiv_step, writes HI/LO
// on the final step and pulses done for one cycle. stall holds the pipeline
// from the request cycle through the last iteration.
// Build option: define MULDIV_SIGNED_EN for two's-complement mult/div; the
// default build is unsigned only and contains no negation logic.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  muldiv_state_t      state_q;
  logic [CW-1:0]      count_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   dividend_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic               dbz_q;

  logic               accept;
  logic               divByZero;
  logic [WIDTH-1:0]   capA;
  logic [WIDTH-1:0]   capB;
  logic [2*WIDTH-1:0] stepAcc;
  logic [WIDTH-1:0]   hiFinal;
  logic [WIDTH-1:0]   loFinal;

`ifdef MULDIV_SIGNED_EN
  logic               negRes_q;
  logic               negRem_q;
`endif

  assign accept    = (state_q == ST_IDLE) && start && isMuldivCode(alucontrol);
  assign stall     = accept | busy_q;
  assign divByZero = (opnd_q == '0);

  assign busy = busy_q;
  assign done = done_q;
  assign dbz  = dbz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Operand capture: the engine always iterates on magnitudes
  always_comb begin
    capA = srca;
    capB = srcb;
`ifdef MULDIV_SIGNED_EN
    if (srca[WIDTH-1]) capA = -srca;
    if (srcb[WIDTH-1]) capB = -srcb;
`endif
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .isDiv_i   (state_q == ST_DIV),
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .acc_o     (stepAcc)
  );

  // Result as written at the final step: sign fix-up, then the divide-by-zero override
  always_comb begin
    hiFinal = stepAcc[2*WIDTH-1:WIDTH];
    loFinal = stepAcc[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
    if (state_q == ST_MUL) begin
      if (negRes_q) {hiFinal, loFinal} = -stepAcc;
    end else begin
      if (negRes_q) loFinal = -stepAcc[WIDTH-1:0];
      if (negRem_q) hiFinal = -stepAcc[2*WIDTH-1:WIDTH];
    end
`endif
    if ((state_q == ST_DIV) && divByZero) begin
      loFinal = '1;
      hiFinal = dividend_q;
    end
  end

  // Controller FSM with step counter and registered status/result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      dividend_q <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      negRes_q   <= 1'b0;
      negRem_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (accept) begin
            count_q    <= '0;
            dbz_q      <= 1'b0;
            busy_q     <= 1'b1;
            dividend_q <= srca;
`ifdef MULDIV_SIGNED_EN
            negRes_q   <= srca[WIDTH-1] ^ srcb[WIDTH-1];
            negRem_q   <= srca[WIDTH-1];
`endif
            if (alucontrol == ALUCTL_DIV) begin
              acc_q   <= {{WIDTH{1'b0}}, capA};
              opnd_q  <= capB;
              state_q <= ST_DIV;
            end else begin
              acc_q   <= {{WIDTH{1'b0}}, capB};
              opnd_q  <= capA;
              state_q <= ST_MUL;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          acc_q   <= stepAcc;
          count_q <= count_q + CW'(1);
          if (count_q == LAST_STEP) begin
            hi_q    <= hiFinal;
            lo_q    <= loFinal;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            dbz_q   <= (state_q == ST_DIV) && divByZero;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
